// File: rtl/rk_uart_pkg.sv
// Shared types and constants for the rk_uart_tx serial transmitter.
// RK_UART_PARITY_EN adds an even-parity bit and the PARITY state.
package rk_uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 87;
    localparam int FRAME_BITS_NO_PAR = 10;
    localparam int FRAME_BITS_PAR = 11;

`ifdef RK_UART_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_PAR;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_t;
`else
    localparam int FRAME_BITS = FRAME_BITS_NO_PAR;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } uart_state_t;
`endif

endpackage

// File: rtl/rk_baud_tick.sv
// Reloadable 16-bit down-counter; tick_o marks the last cycle of a serial bit.
// Holds at zero once it expires so an idle transmitter keeps a stable count.
module rk_baud_tick #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic reload_i,
    input  logic en_i,
    output logic tick_o
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (reload_i) begin
            cnt_d = 16'(CLKS_PER_BIT - 1);
        end else if (en_i && (cnt_q != 16'd0)) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == 16'd0);

endmodule

// File: rtl/rk_uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input and a registered serial line.
// Define RK_UART_PARITY_EN to append an even-parity bit (8E1 framing).
module rk_uart_tx
    import rk_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       busy
);

    uart_state_t state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        tx_q, tx_d;
    logic        reload;
    logic        bit_end;
`ifdef RK_UART_PARITY_EN
    logic        parity_q, parity_d;
`endif

    rk_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk_i   (clk),
        .rst_i   (rst),
        .reload_i(reload),
        .en_i    (busy),
        .tick_o  (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        reload    = 1'b0;
`ifdef RK_UART_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (tx_valid) begin
                    shift_d   = tx_data;
                    bit_idx_d = 3'd0;
                    tx_d      = 1'b0;
                    reload    = 1'b1;
                    state_d   = S_START;
`ifdef RK_UART_PARITY_EN
                    parity_d  = ^tx_data;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    reload  = 1'b1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    reload    = 1'b1;
                    // Increment wraps 7 -> 0 on the final data bit.
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef RK_UART_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef RK_UART_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    reload  = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= 8'h00;
            bit_idx_q <= 3'd0;
            tx_q      <= 1'b1;
`ifdef RK_UART_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
`ifdef RK_UART_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign tx_out   = tx_q;

endmodule

// File: tb/tb_rk_uart_tx.sv
// Self-checking bench for rk_uart_tx: line-level frame model plus mid-bit receiver.
// Parity cases are compiled in when RK_UART_PARITY_EN is defined.
module tb_rk_uart_tx;

    localparam int N = 4;
`ifdef RK_UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_out;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    rk_uart_tx #(
        .CLKS_PER_BIT(N)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_out  (tx_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line level during frame bit i: start, 8 data bits LSB first, [parity], stop.
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef RK_UART_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Presents byte b in the idle slot, checks every cycle of the frame, then the idle cycle.
    task automatic run_frame(input logic [7:0] b, input bit hold, input bit disturb,
                             output logic [7:0] rx, output logic rx_par);
        rx = 8'h00;
        rx_par = 1'b0;
        tx_data = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
        if (disturb) tx_data = 8'hFF;
        for (int i = 0; i < FB; i++) begin
            for (int c = 0; c < N; c++) begin
                @(negedge clk);
                check_val("line", 8'(tx_out), 8'(exp_bit(b, i)));
                if (c == 0) check_val("busy", 8'(busy), 8'h01);
                if (c == N / 2) begin
                    if (i >= 1 && i <= 8) rx[i-1] = tx_out;
                    if (i == 9) rx_par = tx_out;
                end
                if (disturb && i == 4 && c == 0) begin
                    tx_data = 8'($urandom);
                    tx_valid = 1'b1;
                end
                if (disturb && i == 4 && c == 1) tx_valid = 1'b0;
            end
        end
        @(negedge clk);
        check_val("idle_ready", 8'(tx_ready), 8'h01);
        check_val("idle_busy", 8'(busy), 8'h00);
        check_val("idle_line", 8'(tx_out), 8'h01);
        check_val("rx_byte", rx, b);
`ifdef RK_UART_PARITY_EN
        check_val("rx_par", 8'(rx_par), 8'(^b));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rx;
        logic       par;
        logic [7:0] b;

        rst = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            check_val("rst_line", 8'(tx_out), 8'h01);
            check_val("rst_busy", 8'(busy), 8'h00);
        end
        tx_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_ready", 8'(tx_ready), 8'h01);
        check_val("post_rst_busy", 8'(busy), 8'h00);
        check_val("post_rst_line", 8'(tx_out), 8'h01);

        run_frame(8'hA5, 1'b0, 1'b0, rx, par);

`ifdef RK_UART_PARITY_EN
        run_frame(8'h07, 1'b0, 1'b0, rx, par);
        check_val("par_07", 8'(par), 8'h01);
        run_frame(8'h03, 1'b0, 1'b0, rx, par);
        check_val("par_03", 8'(par), 8'h00);
`endif

        // Back-to-back: valid held across both frames, one idle cycle between.
        run_frame(8'h00, 1'b1, 1'b0, rx, par);
        run_frame(8'hFF, 1'b0, 1'b0, rx, par);

        // Reset partway through a frame of 0x55.
        tx_data = 8'h55;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check_val("pre_abort_line", 8'(tx_out), 8'(exp_bit(8'h55, k / N)));
        end
        rst = 1'b1;
        tx_valid = 1'b1;
        @(negedge clk);
        check_val("abort_line", 8'(tx_out), 8'h01);
        check_val("abort_busy", 8'(busy), 8'h00);
        tx_valid = 1'b0;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_val("no_resume_line", 8'(tx_out), 8'h01);
            check_val("no_resume_busy", 8'(busy), 8'h00);
        end
        run_frame(8'h3C, 1'b0, 1'b0, rx, par);

        // Mid-frame data change and ignored valid pulse.
        run_frame(8'h12, 1'b0, 1'b1, rx, par);

        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom);
            run_frame(b, 1'b0, 1'($urandom_range(0, 1)), rx, par);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check_val("gap_line", 8'(tx_out), 8'h01);
                check_val("gap_ready", 8'(tx_ready), 8'h01);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
